// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one instruction-memory read at a time, drives the PC
// register's write port and hands instructions to decode through a one-entry output register.
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    output logic        o_pc_write,
    output logic [31:0] o_next_pc,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload stay stable until then, except that a redirect withdraws the request.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic drain;
    logic slot_free;
    logic req_fire;
    logic rsp_load;

    always_comb begin
        drain            = inst_valid_q & i_inst_ready;
        slot_free        = !inst_valid_q | drain;
        o_imem_req_valid = (state_q == S_REQ) & slot_free & !i_redirect & !i_rst;
        o_imem_addr      = i_pc;
        req_fire         = o_imem_req_valid & i_imem_req_ready;
        // A response landing together with a redirect belongs to the wrong path.
        rsp_load         = (state_q == S_WAIT) & i_imem_rsp_valid & !i_redirect;
        o_pc_write       = !i_rst & (i_redirect | req_fire);
        o_next_pc        = i_redirect ? i_redirect_pc : (i_pc + PC_STEP);
    end

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d  = S_WAIT;
                    req_pc_d = i_pc;
                end
            end
            S_WAIT: begin
                if (i_imem_rsp_valid) begin
                    state_d = S_REQ;
                end else if (i_redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        if (i_redirect) begin
            inst_valid_d = 1'b0;
        end else if (rsp_load) begin
            inst_valid_d = 1'b1;
            inst_d       = i_imem_rsp_data;
            inst_pc_d    = req_pc_q;
        end else if (drain) begin
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_REQ;
            req_pc_q     <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign o_inst_valid = inst_valid_q;
    assign o_inst       = inst_q;
    assign o_inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: models the PC register and an in-order instruction memory;
// a monitor checks every instruction accepted by decode against an expected queue.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] i_pc;
    logic        o_pc_write;
    logic [31:0] o_next_pc;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] pc_reg;

    logic        s_rv, s_pcw, s_iv, s_rspv;
    logic [31:0] s_addr, s_npc, s_inst, s_ipc;

    fetch_unit #(.PC_STEP(32'd4)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pc             (i_pc),
        .o_pc_write       (o_pc_write),
        .o_next_pc        (o_next_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cyc();
        logic        fire;
        logic [31:0] a;
        @(negedge clk);
        s_rv   = o_imem_req_valid;
        s_addr = o_imem_addr;
        s_pcw  = o_pc_write;
        s_npc  = o_next_pc;
        s_iv   = o_inst_valid;
        s_inst = o_inst;
        s_ipc  = o_inst_pc;
        s_rspv = i_imem_rsp_valid;
        fire   = o_imem_req_valid & i_imem_req_ready;
        a      = o_imem_addr;
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (s_pcw) pc_reg = s_npc;
        i_pc       = pc_reg;
        i_redirect = 1'b0;
        if (s_rspv && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (fire) begin
            pend_addr.push_back(a);
            pend_due.push_back(cyc_cnt - 1 + mem_lat);
        end
        if (pend_addr.size() > 0 && pend_due[0] <= cyc_cnt) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem_data(pend_addr[0]);
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = 32'd0;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && o_inst_valid && i_inst_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL inst_unexpected: got pc=%h inst=%h, none expected", o_inst_pc, o_inst);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", o_inst_pc, e[63:32]);
                chk("inst_word", o_inst, e[31:0]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; pc_reg = 32'd0; i_pc = 32'd0;
        i_imem_req_ready = 1'b1; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = 32'd0;
        i_redirect = 1'b0; i_redirect_pc = 32'd0; i_inst_ready = 1'b1;

        cyc();
        chk("rst_inst_valid", 32'(s_iv), 32'd0);
        chk("rst_inst", s_inst, 32'd0);
        chk("rst_inst_pc", s_ipc, 32'd0);
        chk("rst_req_valid", 32'(s_rv), 32'd0);
        chk("rst_pc_write", 32'(s_pcw), 32'd0);
        cyc();
        rst = 1'b0;

        // first fetch after reset, then decode stalls with 0xDEADBEEF held
        cyc();
        chk("a_req_valid", 32'(s_rv), 32'd1);
        chk("a_addr", s_addr, 32'h0);
        chk("a_pc_write", 32'(s_pcw), 32'd1);
        chk("a_next_pc", s_npc, 32'h4);
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        cyc();
        chk("b_req_valid", 32'(s_rv), 32'd0);
        chk("b_pc_write", 32'(s_pcw), 32'd0);
        i_inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("hold_valid", 32'(s_iv), 32'd1);
            chk("hold_inst", s_inst, 32'hDEADBEEF);
            chk("hold_pc", s_ipc, 32'h0);
            chk("hold_req_valid", 32'(s_rv), 32'd0);
        end
        i_inst_ready = 1'b1;
        cyc();
        chk("drain_req_valid", 32'(s_rv), 32'd1);
        chk("drain_addr", s_addr, 32'h4);
        chk("drain_next_pc", s_npc, 32'h8);
        exp_q.push_back({32'h4, 32'hDEADBEEB});
        cyc();
        cyc();
        chk("seq_req_valid", 32'(s_rv), 32'd1);
        chk("seq_addr", s_addr, 32'h8);
        exp_q.push_back({32'h8, 32'hDEADBEE7});
        cyc();

        // memory not ready for three cycles
        i_imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_req_valid", 32'(s_rv), 32'd1);
            chk("stall_addr", s_addr, 32'hC);
            chk("stall_pc_write", 32'(s_pcw), 32'd0);
        end
        i_imem_req_ready = 1'b1;
        cyc();
        chk("accept_pc_write", 32'(s_pcw), 32'd1);
        chk("accept_next_pc", s_npc, 32'h10);
        exp_q.push_back({32'hC, 32'hDEADBEE3});
        cyc();

        // redirect while WAIT, killed response arrives two cycles later
        mem_lat = 3;
        cyc();
        chk("p_addr", s_addr, 32'h10);
        i_redirect = 1'b1; i_redirect_pc = 32'h100;
        cyc();
        chk("redir_pc_write", 32'(s_pcw), 32'd1);
        chk("redir_next_pc", s_npc, 32'h100);
        chk("redir_req_valid", 32'(s_rv), 32'd0);
        mem_lat = 1;
        cyc();
        chk("drain_st_req", 32'(s_rv), 32'd0);
        cyc();
        chk("killed_rsp_seen", 32'(s_rspv), 32'd1);
        chk("killed_rsp_req", 32'(s_rv), 32'd0);
        chk("killed_rsp_iv", 32'(s_iv), 32'd0);
        cyc();
        chk("post_kill_iv", 32'(s_iv), 32'd0);
        chk("post_kill_addr", s_addr, 32'h100);
        chk("post_kill_next_pc", s_npc, 32'h104);
        exp_q.push_back({32'h100, 32'hDEADBFEF});
        cyc();
        cyc();

        // redirect coincident with response
        i_redirect = 1'b1; i_redirect_pc = 32'h200;
        cyc();
        chk("co_rsp_seen", 32'(s_rspv), 32'd1);
        chk("co_next_pc", s_npc, 32'h200);
        chk("co_pc_write", 32'(s_pcw), 32'd1);
        cyc();
        chk("co_dropped_iv", 32'(s_iv), 32'd0);
        chk("co_addr", s_addr, 32'h200);
        exp_q.push_back({32'h200, 32'hDEADBCEF});
        cyc();

        // redirect with an instruction in the slot, drained the same cycle
        i_inst_ready = 1'b0;
        cyc();
        chk("slot_full_iv", 32'(s_iv), 32'd1);
        chk("slot_full_req", 32'(s_rv), 32'd0);
        i_inst_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        cyc();
        chk("slot_redir_next_pc", s_npc, 32'hFFFF_FFFC);
        chk("slot_redir_req", 32'(s_rv), 32'd0);
        cyc();
        chk("slot_cleared_iv", 32'(s_iv), 32'd0);
        chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
        chk("wrap_next_pc", s_npc, 32'h0);
        exp_q.push_back({32'hFFFF_FFFC, 32'h21524113});
        cyc();

        // asynchronous reset while WAIT, stale response after release
        mem_lat = 2;
        cyc();
        chk("pre_rst_addr", s_addr, 32'h0);
        #2;
        chk("pre_rst_inst", o_inst, 32'h21524113);
        rst = 1'b1;
        #1;
        chk("async_inst", o_inst, 32'h0);
        chk("async_inst_pc", o_inst_pc, 32'h0);
        chk("async_req_valid", 32'(o_imem_req_valid), 32'd0);
        chk("async_pc_write", 32'(o_pc_write), 32'd0);
        cyc();
        rst = 1'b0;
        mem_lat = 1;
        cyc();
        chk("stale_rsp_seen", 32'(s_rspv), 32'd1);
        chk("stale_req_valid", 32'(s_rv), 32'd1);
        chk("stale_addr", s_addr, 32'h4);
        exp_q.push_back({32'h4, 32'hDEADBEEB});
        cyc();
        chk("stale_ignored_iv", 32'(s_iv), 32'd0);
        i_imem_req_ready = 1'b0;
        cyc();
        chk("final_iv", 32'(s_iv), 32'd1);
        chk("final_inst_pc", s_ipc, 32'h4);
        cyc();
        cyc();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
